// File: rtl/ysyx_22050039_ctrl_pkg.sv
// Shared types for the NPC multi-cycle execution controller.
// State encoding, error causes and latched decode bundle.
package ysyx_22050039_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_INVALID = 2'd1;
    localparam logic [1:0] ERR_MDU_TO  = 2'd2;
    localparam logic [1:0] ERR_MEM_TO  = 2'd3;

    localparam int WD_W = 16;

    typedef struct packed {
        logic reg_wen;
        logic pc_wen;
        logic is_mdu;
        logic is_load;
        logic is_store;
    } dec_t;

endpackage

// File: rtl/ysyx_22050039_wdog.sv
// Wait-cycle counter for EXEC/MEM stalls.
// tc asserts once the count has reached LIMIT; the count then holds.
import ysyx_22050039_ctrl_pkg::*;

module ysyx_22050039_wdog #(
    parameter int LIMIT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    output logic [WD_W-1:0] cnt,
    output logic            tc
);

    assign tc = (cnt == WD_W'(LIMIT));

    // clear on stage entry, count each stalled cycle
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_22050039_exec_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the NPC core.
// Optional perf counters: define YSYX_22050039_PERF_CNT_EN.
import ysyx_22050039_ctrl_pkg::*;

module ysyx_22050039_exec_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_valid,
    output logic             inst_ready,
    input  logic             dec_reg_wen,
    input  logic             dec_pc_wen,
    input  logic             dec_is_mdu,
    input  logic             dec_is_load,
    input  logic             dec_is_store,
    input  logic             dec_ebreak,
    input  logic             dec_invalid,
    output logic             mdu_start,
    input  logic             mdu_done,
    output logic             mem_req,
    output logic             mem_we,
    input  logic             mem_ack,
    output logic             reg_wen,
    output logic             pc_wen,
    output logic             pc_redirect,
    output logic             halted,
    output logic             error,
    output logic [1:0]       err_code
`ifdef YSYX_22050039_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] inst_cnt
`endif
);

    state_t          state_q;
    state_t          state_d;
    dec_t            dec_q;
    logic [1:0]      err_q;
    logic [1:0]      err_d;
    logic            wd_clr;
    logic            wd_inc;
    logic            wd_tc;
    logic [WD_W-1:0] wd_cnt;

    ysyx_22050039_wdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk (clk),
        .rst (rst),
        .clr (wd_clr),
        .inc (wd_inc),
        .cnt (wd_cnt),
        .tc  (wd_tc)
    );

    // state and sticky error cause
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // capture decode flags while in DECODE
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q <= '0;
        end else if (state_q == DECODE) begin
            dec_q.reg_wen  <= dec_reg_wen;
            dec_q.pc_wen   <= dec_pc_wen;
            dec_q.is_mdu   <= dec_is_mdu;
            dec_q.is_load  <= dec_is_load;
            dec_q.is_store <= dec_is_store;
        end
    end

    // next-state, error cause and watchdog control
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        wd_inc  = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (inst_valid) state_d = DECODE;
            end
            DECODE: begin
                unique case (1'b1)
                    dec_invalid: begin
                        state_d = ERROR;
                        err_d   = ERR_INVALID;
                    end
                    (!dec_invalid && dec_ebreak): begin
                        state_d = HALT;
                    end
                    (!dec_invalid && !dec_ebreak): begin
                        state_d = EXEC;
                    end
                    default: state_d = EXEC;
                endcase
            end
            EXEC: begin
                if (dec_q.is_mdu) begin
                    if (mdu_done) begin
                        state_d = WB;
                    end else if (wd_tc) begin
                        state_d = ERROR;
                        err_d   = ERR_MDU_TO;
                    end else begin
                        wd_inc = 1'b1;
                    end
                end else if (dec_q.is_load || dec_q.is_store) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                if (mem_ack) begin
                    state_d = WB;
                end else if (wd_tc) begin
                    state_d = ERROR;
                    err_d   = ERR_MEM_TO;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            WB:      state_d = FETCH;
            HALT:    state_d = HALT;
            ERROR:   state_d = ERROR;
            default: state_d = FETCH;
        endcase
    end

    // restart the wait count on every state change
    assign wd_clr = (state_d != state_q);

    assign inst_ready  = (state_q == FETCH);
    assign mdu_start   = (state_q == EXEC) && dec_q.is_mdu
                       && (wd_cnt == '0);
    assign mem_req     = (state_q == MEM);
    assign mem_we      = (state_q == MEM) && dec_q.is_store;
    assign reg_wen     = (state_q == WB) && dec_q.reg_wen;
    assign pc_wen      = (state_q == WB);
    assign pc_redirect = (state_q == WB) && dec_q.pc_wen;
    assign halted      = (state_q == HALT);
    assign error       = (state_q == ERROR);
    assign err_code    = err_q;

`ifdef YSYX_22050039_PERF_CNT_EN
    // running cycle and retired-instruction counters
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt  <= '0;
            inst_cnt <= '0;
        end else begin
            if (state_q != HALT && state_q != ERROR)
                cyc_cnt <= cyc_cnt + 1'b1;
            if (state_q == WB)
                inst_cnt <= inst_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22050039_exec_ctrl.sv
// Directed self-checking bench for the execution controller.
// Cycle N = N-th cycle after the handshake cycle 0.
module tb_ysyx_22050039_exec_ctrl;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inst_valid = 1'b0;
    logic       inst_ready;
    logic       dec_reg_wen = 1'b0;
    logic       dec_pc_wen = 1'b0;
    logic       dec_is_mdu = 1'b0;
    logic       dec_is_load = 1'b0;
    logic       dec_is_store = 1'b0;
    logic       dec_ebreak = 1'b0;
    logic       dec_invalid = 1'b0;
    logic       mdu_start;
    logic       mdu_done = 1'b0;
    logic       mem_req;
    logic       mem_we;
    logic       mem_ack = 1'b0;
    logic       reg_wen;
    logic       pc_wen;
    logic       pc_redirect;
    logic       halted;
    logic       error;
    logic [1:0] err_code;
`ifdef YSYX_22050039_PERF_CNT_EN
    logic [63:0] cyc_cnt;
    logic [63:0] inst_cnt;
`endif

    int n_chk = 0;
    int n_pass = 0;
    int n_reg = 0;
    int n_pc = 0;
    int n_start = 0;

    ysyx_22050039_exec_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .dec_reg_wen  (dec_reg_wen),
        .dec_pc_wen   (dec_pc_wen),
        .dec_is_mdu   (dec_is_mdu),
        .dec_is_load  (dec_is_load),
        .dec_is_store (dec_is_store),
        .dec_ebreak   (dec_ebreak),
        .dec_invalid  (dec_invalid),
        .mdu_start    (mdu_start),
        .mdu_done     (mdu_done),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_ack      (mem_ack),
        .reg_wen      (reg_wen),
        .pc_wen       (pc_wen),
        .pc_redirect  (pc_redirect),
        .halted       (halted),
        .error        (error),
        .err_code     (err_code)
`ifdef YSYX_22050039_PERF_CNT_EN
        ,
        .cyc_cnt      (cyc_cnt),
        .inst_cnt     (inst_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            if (reg_wen)   n_reg   <= n_reg + 1;
            if (pc_wen)    n_pc    <= n_pc + 1;
            if (mdu_start) n_start <= n_start + 1;
        end
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_dec();
        dec_reg_wen  = 1'b0;
        dec_pc_wen   = 1'b0;
        dec_is_mdu   = 1'b0;
        dec_is_load  = 1'b0;
        dec_is_store = 1'b0;
        dec_ebreak   = 1'b0;
        dec_invalid  = 1'b0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        inst_valid = 1'b0;
        mdu_done   = 1'b0;
        mem_ack    = 1'b0;
        clr_dec();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // handshake in cycle 0, decode in cycle 1; returns in cycle 2
    task automatic start(input logic rw, input logic pw,
                         input logic md, input logic ld,
                         input logic st, input logic eb,
                         input logic inv);
        inst_valid   = 1'b1;
        dec_reg_wen  = rw;
        dec_pc_wen   = pw;
        dec_is_mdu   = md;
        dec_is_load  = ld;
        dec_is_store = st;
        dec_ebreak   = eb;
        dec_invalid  = inv;
        cyc();
        inst_valid = 1'b0;
        cyc();
        clr_dec();
    endtask

    initial begin
        int r0;
        int p0;
        int s0;
        int rdy;

        do_reset();
        check("rst_ready", inst_ready, 1);
        check("rst_outs",
              {mdu_start, mem_req, mem_we, reg_wen,
               pc_wen, pc_redirect, halted, error}, 0);
        check("rst_err", err_code, 0);

        // addi
        r0 = n_reg;
        p0 = n_pc;
        start(1, 0, 0, 0, 0, 0, 0);
        check("addi_c2", {reg_wen, pc_wen}, 0);
        cyc();
        check("addi_c3", {reg_wen, pc_wen, pc_redirect}, 3'b110);
        cyc();
        check("addi_c4", {inst_ready, reg_wen, pc_wen}, 3'b100);
        check("addi_cnt", n_reg - r0 + 10 * (n_pc - p0), 11);

        // jal
        start(1, 1, 0, 0, 0, 0, 0);
        cyc();
        check("jal_c3", {reg_wen, pc_wen, pc_redirect}, 3'b111);
        cyc();

        // ld, ack in cycle 7
        start(1, 0, 0, 1, 0, 0, 0);
        check("ld_c2", mem_req, 0);
        for (int c = 3; c <= 7; c++) begin
            cyc();
            check($sformatf("ld_req_c%0d", c), {mem_req, mem_we}, 2'b10);
            if (c == 7) mem_ack = 1'b1;
        end
        cyc();
        mem_ack = 1'b0;
        check("ld_c8", {mem_req, reg_wen, pc_wen}, 3'b011);
        cyc();
        check("ld_c9", inst_ready, 1);

        // sd, stray ack before MEM is ignored
        inst_valid   = 1'b1;
        dec_is_store = 1'b1;
        cyc();
        inst_valid = 1'b0;
        mem_ack    = 1'b1;
        cyc();
        clr_dec();
        for (int c = 3; c <= 7; c++) begin
            mem_ack = 1'b0;
            cyc();
            check($sformatf("sd_req_c%0d", c), {mem_req, mem_we}, 2'b11);
            if (c == 7) mem_ack = 1'b1;
        end
        cyc();
        mem_ack = 1'b0;
        check("sd_c8", {mem_req, reg_wen, pc_wen}, 3'b001);
        cyc();

        // divw, done 10 cycles after start
        s0 = n_start;
        r0 = n_reg;
        start(1, 0, 1, 1, 0, 0, 0);
        check("div_start_c2", mdu_start, 1);
        for (int c = 3; c <= 12; c++) begin
            cyc();
            if (c == 12) mdu_done = 1'b1;
        end
        check("div_c12", {mdu_start, mem_req, reg_wen}, 0);
        cyc();
        mdu_done = 1'b0;
        check("div_c13", {reg_wen, pc_wen, mem_req}, 3'b110);
        cyc();
        check("div_starts", n_start - s0, 1);
        check("div_regs", n_reg - r0, 1);

        // MDU done on first EXEC cycle
        start(1, 0, 1, 0, 0, 0, 0);
        mdu_done = 1'b1;
        cyc();
        mdu_done = 1'b0;
        check("div_fast_c3", {reg_wen, pc_wen}, 2'b11);
        cyc();

        // done on the very cycle the count reaches TO
        start(1, 0, 1, 0, 0, 0, 0);
        for (int c = 3; c <= TO + 2; c++) cyc();
        mdu_done = 1'b1;
        cyc();
        mdu_done = 1'b0;
        check("div_edge", {error, reg_wen, pc_wen}, 3'b011);
        cyc();

        // MDU timeout
        r0 = n_reg;
        start(1, 0, 1, 0, 0, 0, 0);
        for (int c = 3; c <= TO + 2; c++) cyc();
        check("mto_pre", error, 0);
        cyc();
        check("mto_err", {error, err_code}, 3'b110);
        for (int c = 0; c < 5; c++) cyc();
        check("mto_noreg", n_reg - r0, 0);
        check("mto_ready", inst_ready, 0);

        // memory timeout
        do_reset();
        start(1, 0, 0, 1, 0, 0, 0);
        for (int c = 3; c <= TO + 3; c++) cyc();
        check("memto_pre", {error, mem_req}, 2'b01);
        cyc();
        check("memto_err", {error, err_code, mem_req}, 4'b1110);

        // ebreak
        do_reset();
        p0 = n_pc;
        start(0, 0, 0, 0, 0, 1, 0);
        check("ebrk_c2", {halted, error}, 2'b10);
        inst_valid = 1'b1;
        rdy = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (inst_ready !== 1'b0 || halted !== 1'b1) rdy++;
        end
        check("ebrk_hold", rdy, 0);
        check("ebrk_nopc", n_pc - p0, 0);
        do_reset();
        check("ebrk_rst", {halted, inst_ready}, 2'b01);

        // invalid with ebreak
        start(0, 0, 0, 0, 0, 1, 1);
        check("inv_c2", {error, halted, err_code}, 4'b1001);
        do_reset();
        check("inv_rst", {error, err_code}, 0);

        // reset in the middle of MEM
        r0 = n_reg;
        p0 = n_pc;
        start(1, 0, 0, 1, 0, 0, 0);
        cyc();
        cyc();
        check("rmem_c4", mem_req, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rmem_req", {mem_req, inst_ready}, 2'b01);
        check("rmem_nowb", n_pc - p0, 0);
        start(1, 0, 0, 0, 0, 0, 0);
        cyc();
        check("rmem_next", {reg_wen, pc_wen}, 2'b11);
        check("rmem_regs", n_reg - r0, 0);
        cyc();

`ifdef YSYX_22050039_PERF_CNT_EN
        do_reset();
        inst_valid  = 1'b1;
        dec_reg_wen = 1'b1;
        for (int c = 0; c < 12; c++) cyc();
        inst_valid = 1'b0;
        clr_dec();
        check("perf_inst", inst_cnt, 3);
        check("perf_cyc", cyc_cnt, 12);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=done");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/ysyx_22050039_exec_ctrl.md
Name: ysyx_22050039_exec_ctrl

Overview:
Multi-cycle sequencer for the single-issue NPC core: it sits between IFU, IDU, EXU, LSU and the multiply/divide unit (MDU). It steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It gates the register-file write enable and the PC write enable so each fires exactly once per retired instruction. It stalls on multi-cycle MDU ops (div/rem) and memory handshakes, halts on ebreak, and traps on invalid instructions and watchdog timeouts.

Parameters:
TIMEOUT_CYCLES, 255, maximum wait cycles in EXEC (MDU op) or MEM before a timeout error; must be in the range 1..65535.
CNT_W, 64, width of the performance counters (used only when the optional feature is compiled in).

Ports:
clk  in  1  core clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
inst_valid  in  1  IFU has an instruction.
inst_ready  out  1  controller accepts the instruction; high only in FETCH.
dec_reg_wen  in  1  decoded instruction writes rd; sampled in DECODE.
dec_pc_wen  in  1  decoded instruction redirects the PC (jal/jalr/branch); sampled in DECODE.
dec_is_mdu  in  1  instruction uses the MDU.
dec_is_load  in  1  load.
dec_is_store  in  1  store.
dec_ebreak  in  1  ebreak.
dec_invalid  in  1  undecodable instruction.
mdu_start  out  1  one-cycle start pulse to the MDU.
mdu_done  in  1  MDU result valid.
mem_req  out  1  LSU request; held high until acknowledged.
mem_we  out  1  store when high; valid while mem_req is high.
mem_ack  in  1  LSU completion.
reg_wen  out  1  register-file write strike; single-cycle pulse in WB.
pc_wen  out  1  PC update strike; single-cycle pulse in WB (PC advances for every instruction).
pc_redirect  out  1  in WB, selects the branch/jump target rather than pc+4.
halted  out  1  sticky; set by ebreak.
error  out  1  sticky; set on error.
err_code  out  2  error cause: 0 none, 1 invalid instruction, 2 MDU timeout, 3 memory timeout.

Behaviour:
- Reset (rst high at a posedge): state=FETCH, wait counter=0, latched decode flags=0, every output 0 except inst_ready. Reset in any state, including mid-MEM or mid-MDU, abandons the instruction; mem_req and mdu_start are 0 from the next cycle.
- FETCH: inst_ready=1. If inst_valid, go to DECODE. Otherwise stay.
- DECODE (1 cycle): latch all dec_* flags.
  - dec_invalid → ERROR, err_code=1.
  - else dec_ebreak → HALT.
  - else → EXEC.
  - If dec_invalid and dec_ebreak are both high, invalid wins.
- EXEC, non-MDU: 1 cycle. Load/store → MEM; otherwise → WB.
- EXEC, MDU:
  - mdu_start=1 only on the first EXEC cycle.
  - Wait for mdu_done; done is accepted on any EXEC cycle, including the first.
  - On done → WB (dec_is_mdu has priority over load/store flags).
- MEM: mem_req=1 and mem_we=latched store. Hold until mem_ack is sampled high, then → WB. mem_ack received outside MEM is ignored.
- Watchdog:
  - Counter clears on entry to EXEC and MEM, and increments each waiting cycle.
  - If the counter reaches TIMEOUT_CYCLES with no completion → ERROR, err_code=2 (EXEC) or 3 (MEM).
  - If completion arrives in the same cycle the count is reached, completion wins.
- WB (1 cycle): pc_wen=1; reg_wen=latched dec_reg_wen; pc_redirect=latched dec_pc_wen. Then → FETCH.
- HALT, ERROR: terminal until reset. inst_ready=0. halted or error=1. No further reg_wen or pc_wen.
- Latency, ALU/jump instruction: handshake at cycle 0, DECODE 1, EXEC 2, WB 3, inst_ready again at 4.
  - Load/store: 5 + (ack wait) cycles.
  - MDU: 4 + (done wait) cycles.
- Encode the state as a 3-bit enum. All outputs are decoded from registered state and latched flags; there is no combinational path from dec_* to outputs.

Optional Feature:
YSYX_22050039_PERF_CNT_EN: adds outputs cyc_cnt[CNT_W] and inst_cnt[CNT_W].
- cyc_cnt increments every non-reset cycle while not HALT/ERROR.
- inst_cnt increments on each WB cycle.
- Both clear on rst and wrap modulo 2^CNT_W.
- Without the macro these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package ysyx_22050039_ctrl_pkg: state enum (FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR) and err_code constants (ERR_NONE, ERR_INVALID, ERR_MDU_TO, ERR_MEM_TO).
- One natural sub-module: ysyx_22050039_wdog, the loadable/clearable wait counter with a terminal-count flag.

Test Plan:
- addi (dec_reg_wen=1), inst_valid at cycle 0 → reg_wen=1 and pc_wen=1 in cycle 3 only, pc_redirect=0, inst_ready=1 in cycle 4.
- ld with mem_ack delayed 4 cycles → mem_req high in cycles 3–7, mem_we=0, reg_wen pulse in cycle 8. sd → same timing with mem_we=1 and reg_wen=0.
- divw, mdu_done 10 cycles after start → single mdu_start in cycle 2, WB one cycle after done. divw with TIMEOUT_CYCLES=8 and no done → error=1, err_code=2, no reg_wen ever.
- ebreak → halted=1 from cycle 2; inst_ready stays 0 for 20 cycles with inst_valid held; rst → FETCH, halted=0. Invalid together with ebreak → err_code=1.
- rst asserted while in MEM → mem_req=0 next cycle, no WB pulse; the next instruction executes normally.
- With YSYX_22050039_PERF_CNT_EN: 3 addi back-to-back → inst_cnt=3, cyc_cnt=12 at the end of the third WB+1.
